// File: rtl/rot_byte_serializer_pkg.sv
// Shared types and frame constants for the rotate-unit byte serializer.
// Frame length depends on SER_PARITY_EN.
package rot_ser_pkg;
    localparam int DATA_W = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_state_t;
endpackage

// File: rtl/rot_byte_serializer_if.sv
// Byte handshake plus serial-line status between the rotator and the serializer.
interface rot_byte_serializer_if;
    import rot_ser_pkg::*;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (output data_in, data_valid, input data_ready, tx, busy, done);
    modport slave  (input data_in, data_valid, output data_ready, tx, busy, done);
endinterface

// File: rtl/ser_bit_timer.sv
// Bit-period down-counter: tick marks a bit boundary, counter rests at zero when not reloaded.
module ser_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = RELOAD;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/rot_byte_serializer.sv
// Async-serial frame transmitter for rotator output bytes (start, 8 data LSB-first, stop).
// Define SER_PARITY_EN to insert an even-parity bit before the stop bit.
module rot_byte_serializer
    import rot_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input logic                 clk,
    input logic                 reset,
    rot_byte_serializer_if.slave bus
);
    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              timer_load, bit_tick, accept;
`ifdef SER_PARITY_EN
    logic              par_q, par_d;
`endif

    ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .tick  (bit_tick)
    );

    // ready_q is only high in IDLE, so a held valid cannot re-accept mid-frame
    assign accept = bus.data_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
`ifdef SER_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                state_d    = START;
                shreg_d    = bus.data_in;
                bit_cnt_d  = '0;
                tx_d       = 1'b0;
                busy_d     = 1'b1;
                ready_d    = 1'b0;
                timer_load = 1'b1;
`ifdef SER_PARITY_EN
                par_d      = ^bus.data_in;
`endif
            end
            START: if (bit_tick) begin
                state_d    = DATA;
                tx_d       = shreg_q[0];
                timer_load = 1'b1;
            end
            DATA: if (bit_tick) begin
                timer_load = 1'b1;
                shreg_d    = shreg_q >> 1;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    tx_d = shreg_q[1];
                end
            end
`ifdef SER_PARITY_EN
            PARITY: if (bit_tick) begin
                state_d    = STOP;
                tx_d       = 1'b1;
                timer_load = 1'b1;
            end
`endif
            // timer is already at zero here and stays there through IDLE
            STOP: if (bit_tick) begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef SER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.data_ready = ready_q;
endmodule

// File: tb/tb_rot_byte_serializer.sv
// Bench for rot_byte_serializer: frame-level reference model checked every cycle,
// table of known frames, and hand sequences for back-to-back, reset and idle cases.
module tb_rot_byte_serializer;
    import rot_ser_pkg::*;

    localparam int CPB  = 4;
    localparam int FLEN = FRAME_BITS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rot_byte_serializer_if bus();

    rot_byte_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model: position within the current frame, in clock cycles
    bit          m_act  = 1'b0;
    int          m_pos  = 0;
    bit          m_done = 1'b0;
    logic [10:0] m_frame = '1;
    bit          chk_en = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frm;   // start, d0..d7, stop; index 0 sent first
        logic       par;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [10:0] build_frame(input logic [7:0] d);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef SER_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    function automatic logic tbl_bit(input vec_t v, input int b);
`ifdef SER_PARITY_EN
        if (b == 9)  return v.par;
        if (b == 10) return v.frm[9];
`endif
        return v.frm[b];
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit acc;
        @(posedge clk);
        if (reset) begin
            m_act  = 1'b0;
            m_done = 1'b0;
        end else begin
            acc    = !m_act && bus.data_valid;
            m_done = 1'b0;
            if (m_act) begin
                m_pos++;
                if (m_pos == FLEN*CPB) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (acc) begin
                m_act   = 1'b1;
                m_pos   = 0;
                m_frame = build_frame(bus.data_in);
            end
        end
        #1;
        if (chk_en) begin
            check1("model_tx",    bus.tx,         m_act ? m_frame[m_pos/CPB] : 1'b1);
            check1("model_busy",  bus.busy,       m_act);
            check1("model_ready", bus.data_ready, !m_act);
            check1("model_done",  bus.done,       m_done);
        end
    endtask

    // one accept edge, then sample mid-bit against the table; ends in the done cycle
    task automatic send_tbl(input int i, input bit hold, input logic [7:0] next_d);
        bus.data_valid = 1'b1;
        bus.data_in    = tbl[i].d;
        step();
        if (!hold) bus.data_valid = 1'b0;
        bus.data_in = next_d;
        for (int k = 0; k < FLEN*CPB; k++) begin
            if (k % CPB == 1)
                check1($sformatf("tbl%0d_bit%0d", i, k/CPB), bus.tx, tbl_bit(tbl[i], k/CPB));
            step();
        end
        check1($sformatf("tbl%0d_done", i), bus.done, 1'b1);
    endtask

    initial begin
        tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
        tbl[1] = '{8'h01, 10'b1000000010, 1'b1};
        tbl[2] = '{8'h80, 10'b1100000000, 1'b1};
        tbl[3] = '{8'h07, 10'b1000001110, 1'b1};
        tbl[4] = '{8'h03, 10'b1000000110, 1'b0};
        tbl[5] = '{8'hFF, 10'b1111111110, 1'b0};
        tbl[6] = '{8'h3C, 10'b1001111000, 1'b0};

        reset = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        step();
        step();
        chk_en = 1'b1;
        check1("rst_tx",    bus.tx,         1'b1);
        check1("rst_busy",  bus.busy,       1'b0);
        check1("rst_done",  bus.done,       1'b0);
        check1("rst_ready", bus.data_ready, 1'b1);
        reset = 1'b0;
        step();

        // every table frame, including the parity pair 07/03
        for (int i = 0; i < 7; i++) begin
            send_tbl(i, 1'b0, 8'h00);
            step();
        end

        // held valid, data changed mid-frame: one more accept, in the done cycle
        send_tbl(1, 1'b1, 8'h80);
        check1("b2b_ready_in_done", bus.data_ready, 1'b1);
        send_tbl(2, 1'b0, 8'h00);
        step();

        // reset during DATA bit 3 of 0xFF
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hFF;
        step();
        bus.data_valid = 1'b0;
        repeat (CPB + 3*CPB + 1) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check1("midrst_tx",    bus.tx,         1'b1);
        check1("midrst_busy",  bus.busy,       1'b0);
        check1("midrst_ready", bus.data_ready, 1'b1);
        repeat (50) step();
        send_tbl(6, 1'b0, 8'h00);
        step();

        // valid held through reset: accept only on the first edge after release
        reset = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hA5;
        repeat (3) begin
            step();
            check1("rsthold_busy", bus.busy, 1'b0);
        end
        reset = 1'b0;
        step();
        check1("rsthold_accept_busy", bus.busy, 1'b1);
        check1("rsthold_accept_tx",   bus.tx,   1'b0);
        bus.data_valid = 1'b0;
        repeat (FLEN*CPB + 2) step();

        // long idle
        repeat (100) step();

        // random traffic with occasional reset
        repeat (3000) begin
            bus.data_valid = ($urandom_range(0, 3) == 0);
            bus.data_in    = 8'($urandom);
            reset          = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        bus.data_valid = 1'b0;
        repeat (FLEN*CPB + 5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
